quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder.sv | 177 +++++++++++++++++
 tb/tb_quad_decoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: two-flop input sync, up/down position count, step/dir pulses, sticky error.
// Define QDEC_FILTER_EN to compile in a glitch filter of FILTER_LEN stable cycles ahead of the decoder.
module quad_decoder #(
    parameter int WIDTH      = 16,
    parameter int FILTER_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             dir,
    output logic             error
);
    logic [1:0]       raw_pair;
    logic [1:0]       sampled;
    logic [1:0]       cur;
    logic [1:0]       prev_reg;
    logic [1:0]       init_reg;
    logic             init_done;
    logic [1:0]       pos_cur;
    logic [1:0]       pos_prev;
    logic [1:0]       delta;
    logic             is_up;
    logic             is_down;
    logic             is_bad;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             step_reg;
    logic             step_next;
    logic             dir_reg;
    logic             dir_next;
    logic             error_reg;
    logic             error_next;

    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
        $error("quad_decoder: FILTER_LEN must be in 1..15");
    end

    assign raw_pair = {quad_a, quad_b};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= raw_pair[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign sampled[gi] = s2_reg;
        end
    endgenerate

    // Three post-reset cycles let prev settle onto the real input level.
    assign init_done = (init_reg == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_reg <= 2'd0;
        end else if (!init_done) begin
            init_reg <= init_reg + 2'd1;
        end
    end

`ifdef QDEC_FILTER_EN
    logic [1:0] filt_reg;
    logic [1:0] cand_reg;
    logic [3:0] run_reg;
    logic [3:0] run_next;

    // Length of the current run of identical samples that differ from the filtered pair.
    always_comb begin
        run_next = 4'd1;
        if (sampled == cand_reg && run_reg != 4'd0) begin
            run_next = run_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_reg <= 2'b00;
            cand_reg <= 2'b00;
            run_reg  <= 4'd0;
        end else if (!init_done) begin
            filt_reg <= sampled;
            cand_reg <= sampled;
            run_reg  <= 4'd0;
        end else if (sampled == filt_reg) begin
            run_reg <= 4'd0;
        end else begin
            cand_reg <= sampled;
            if (run_next >= 4'(FILTER_LEN)) begin
                filt_reg <= sampled;
                run_reg  <= 4'd0;
            end else begin
                run_reg <= run_next;
            end
        end
    end

    assign cur = filt_reg;
`else
    assign cur = sampled;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_reg <= 2'b00;
        end else if (!init_done) begin
            prev_reg <= sampled;
        end else begin
            prev_reg <= cur;
        end
    end

    // Map the Gray pair {a,b} onto a 0..3 phase; the phase difference classifies the move.
    always_comb begin
        pos_cur  = {cur[0], cur[1] ^ cur[0]};
        pos_prev = {prev_reg[0], prev_reg[1] ^ prev_reg[0]};
        delta    = pos_cur - pos_prev;
        is_up    = (delta == 2'd1);
        is_down  = (delta == 2'd3);
        is_bad   = (delta == 2'd2);
    end

    always_comb begin
        count_next = count_reg;
        step_next  = 1'b0;
        dir_next   = dir_reg;
        error_next = error_reg;
        if (init_done) begin
            if (is_up) begin
                count_next = count_reg + WIDTH'(1);
                step_next  = 1'b1;
                dir_next   = 1'b1;
            end else if (is_down) begin
                count_next = count_reg - WIDTH'(1);
                step_next  = 1'b1;
                dir_next   = 1'b0;
            end else if (is_bad) begin
                error_next = 1'b1;
            end
        end
        if (clear) begin
            count_next = '0;
            error_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
            step_reg  <= 1'b0;
            dir_reg   <= 1'b1;
            error_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            step_reg  <= step_next;
            dir_reg   <= dir_next;
            error_reg <= error_next;
        end
    end

    assign count = count_reg;
    assign step  = step_reg;
    assign dir   = dir_reg;
    assign error = error_reg;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: WIDTH=16 and WIDTH=4 instances share stimulus and are
// checked every cycle against a phase-table model, plus directed literal expectations.
module tb_quad_decoder;
`ifdef QDEC_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int FL  = 3;
    localparam int LAT = FILT ? 2 + FL : 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        quad_a = 1'b0;
    logic        quad_b = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] c16;
    logic [3:0]  c4;
    logic        step16, dir16, err16;
    logic        step4, dir4, err4;

    int checks = 0;
    int failures = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    quad_decoder #(.WIDTH(16), .FILTER_LEN(FL)) dut16 (
        .clk(clk), .rst_n(rst_n), .quad_a(quad_a), .quad_b(quad_b), .clear(clear),
        .count(c16), .step(step16), .dir(dir16), .error(err16)
    );

    quad_decoder #(.WIDTH(4), .FILTER_LEN(FL)) dut4 (
        .clk(clk), .rst_n(rst_n), .quad_a(quad_a), .quad_b(quad_b), .clear(clear),
        .count(c4), .step(step4), .dir(dir4), .error(err4)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0]  in_q[$];
    logic [1:0]  samp_q[$];
    logic [1:0]  m_prev, m_filt;
    int          m_init;
    bit          model_valid = 1'b0;
    logic [15:0] exp_c16;
    logic [3:0]  exp_c4;
    logic        exp_step, exp_dir, exp_err;

    // Position of a pair in the up-counting Gray sequence 00,10,11,01.
    function automatic int gray_pos(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [1:0] sampled;
        logic [1:0] cur;
        int         d;
        bit         stable;
        if (!rst_n) begin
            in_q.delete();
            in_q.push_back(2'b00);
            in_q.push_back(2'b00);
            samp_q.delete();
            m_prev = 2'b00;
            m_filt = 2'b00;
            m_init = 3;
            exp_c16 = '0;
            exp_c4 = '0;
            exp_step = 1'b0;
            exp_dir = 1'b1;
            exp_err = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            sampled = in_q[in_q.size() - 2];
            in_q.push_back({quad_a, quad_b});
            if (in_q.size() > 8) void'(in_q.pop_front());
            exp_step = 1'b0;
            if (m_init > 0) begin
                m_init--;
                m_prev = sampled;
                m_filt = sampled;
            end else begin
                cur = FILT ? m_filt : sampled;
                d = (gray_pos(cur) - gray_pos(m_prev) + 4) % 4;
                if (d == 1) begin
                    exp_c16 = exp_c16 + 16'd1;
                    exp_c4 = exp_c4 + 4'd1;
                    exp_step = 1'b1;
                    exp_dir = 1'b1;
                end else if (d == 3) begin
                    exp_c16 = exp_c16 - 16'd1;
                    exp_c4 = exp_c4 - 4'd1;
                    exp_step = 1'b1;
                    exp_dir = 1'b0;
                end else if (d == 2) begin
                    exp_err = 1'b1;
                end
                m_prev = cur;
                samp_q.push_back(sampled);
                if (samp_q.size() > FL) void'(samp_q.pop_front());
                stable = (samp_q.size() == FL);
                foreach (samp_q[i]) if (samp_q[i] != sampled) stable = 1'b0;
                if (stable) m_filt = sampled;
            end
            if (clear) begin
                exp_c16 = '0;
                exp_c4 = '0;
                exp_err = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("cmp_count16", int'(c16), int'(exp_c16));
            chk("cmp_step16", int'(step16), int'(exp_step));
            chk("cmp_dir16", int'(dir16), int'(exp_dir));
            chk("cmp_err16", int'(err16), int'(exp_err));
            chk("cmp_count4", int'(c4), int'(exp_c4));
            chk("cmp_step4", int'(step4), int'(exp_step));
            chk("cmp_dir4", int'(dir4), int'(exp_dir));
            chk("cmp_err4", int'(err4), int'(exp_err));
        end
        if (step16) pulses++;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] p);
        quad_a = p[1];
        quad_b = p[0];
    endtask

    initial begin
        logic [1:0] up_seq[4];
        int p0;
        up_seq[0] = 2'b10;
        up_seq[1] = 2'b11;
        up_seq[2] = 2'b01;
        up_seq[3] = 2'b00;

        // Reset state
        tick(3);
        chk("rst_count16", int'(c16), 0);
        chk("rst_count4", int'(c4), 0);
        chk("rst_step", int'(step16), 0);
        chk("rst_dir", int'(dir16), 1);
        chk("rst_err", int'(err16), 0);
        rst_n = 1'b1;
        tick(5);

        // Four full up cycles at 10-cycle spacing
        p0 = pulses;
        for (int c = 0; c < 4; c++) begin
            for (int t = 0; t < 4; t++) begin
                drive(up_seq[t]);
                tick(10);
                $display("up step %0d: count16=%0d count4=%0d", c * 4 + t + 1, c16, c4);
            end
        end
        chk("up16_count16", int'(c16), 16);
        chk("up16_count4_wrap", int'(c4), 0);
        chk("up16_pulses", pulses - p0, 16);
        chk("up16_dir", int'(dir16), 1);
        chk("up16_err", int'(err16), 0);

        // Wrap below zero, then back up
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(2);
        drive(2'b01);
        tick(10);
        $display("down from 0: count16=%0d count4=%0d dir=%0d", c16, c4, dir4);
        chk("wrap_down_count4", int'(c4), 15);
        chk("wrap_down_count16", int'(c16), 65535);
        chk("wrap_down_dir", int'(dir4), 0);
        drive(2'b00);
        tick(10);
        $display("up from all-ones: count4=%0d dir=%0d", c4, dir4);
        chk("wrap_up_count4", int'(c4), 0);
        chk("wrap_up_dir", int'(dir4), 1);

        // Illegal 00 -> 11 jump, then clear
        p0 = pulses;
        drive(2'b11);
        tick(10);
        $display("illegal 00->11: error=%0d count16=%0d", err16, c16);
        chk("illegal_err", int'(err16), 1);
        chk("illegal_count", int'(c16), 0);
        chk("illegal_no_step", pulses - p0, 0);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1);
        $display("clear after illegal: error=%0d count16=%0d", err16, c16);
        chk("clear_err", int'(err16), 0);
        chk("clear_count", int'(c16), 0);

        // Clear coinciding with a detected up step
        drive(2'b01);
        tick(10);
        chk("pre_clear_count", int'(c16), 1);
        drive(2'b00);
        tick(LAT);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        $display("clear with step: count16=%0d step=%0d dir=%0d", c16, step16, dir16);
        chk("clr_step_count", int'(c16), 0);
        chk("clr_step_step", int'(step16), 1);
        chk("clr_step_dir", int'(dir16), 1);
        tick(10);

        // Mid-sequence reset with inputs held at 11
        drive(2'b10);
        tick(10);
        drive(2'b11);
        tick(10);
        chk("pre_reset_count", int'(c16), 2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        p0 = pulses;
        tick(12);
        $display("after reset at 11: count16=%0d error=%0d pulses=%0d", c16, err16, pulses - p0);
        chk("rst11_count", int'(c16), 0);
        chk("rst11_err", int'(err16), 0);
        chk("rst11_no_step", pulses - p0, 0);
        chk("rst11_dir", int'(dir16), 1);

        // Short glitch on A, then a held rise with latency check
        drive(2'b01);
        tick(10);
        drive(2'b00);
        tick(10);
        p0 = pulses;
        drive(2'b10);
        tick(2);
        drive(2'b00);
        tick(15);
        $display("2-cycle glitch: pulses=%0d count16=%0d", pulses - p0, c16);
        chk("glitch_pulses", pulses - p0, FILT ? 0 : 2);
        chk("glitch_count", int'(c16), 2);
        p0 = pulses;
        drive(2'b10);
        tick(LAT);
        chk("latency_early", int'(step16), 0);
        tick(1);
        chk("latency_step", int'(step16), 1);
        tick(10);
        $display("held rise: pulses=%0d count16=%0d", pulses - p0, c16);
        chk("held_pulses", pulses - p0, 1);
        chk("held_count", int'(c16), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
